// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types, BCD limits and digit helpers for the
//               countdown timer (M:SS, 0:00 to 9:59).
// Contents    : state_t    - controller states IDLE/RUN/PAUSE/DONE
//               bcd_time_t - packed {minutes units, seconds tens, seconds units}
//               clamp_digit, bcd_dec - capture clamp and one-second decrement
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  typedef struct packed {
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  // Saturate an entered digit to its legal BCD range.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                             input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second decrement with borrow. 0:00 is a fixed point so the value
  // can never wrap below zero.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != '0) begin
      if (t.sec_u != 4'd0) begin
        r.sec_u = t.sec_u - 4'd1;
      end else begin
        r.sec_u = UNITS_MAX;
        if (t.sec_t != 4'd0) begin
          r.sec_t = t.sec_t - 4'd1;
        end else begin
          r.sec_t = TENS_MAX;
          r.min_u = t.min_u - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/second_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : second_tick_gen
// Description : Free-running divider that marks the last cycle of each
//               second. Count advances only while en=1 and is held otherwise,
//               so a paused timer resumes mid-second.
// Ports       : clk  in  system clock
//               rst  in  synchronous active-high reset
//               clr  in  zero the count (overrides en)
//               en   in  advance the count this cycle
//               tick out high on the wrap cycle (count == TICKS_PER_SEC-1, en=1)
// Revision    : 1.0 - initial release
// ============================================================================
module second_tick_gen #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational so the owner can decrement on the same edge the count wraps.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : second_tick_gen
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : M:SS countdown (0:00 to 9:59) fed by the timer-entry stage.
//               Decrements once per second while running, pauses on stop,
//               pulses done for one cycle on reaching 0:00.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               units_of_seconds_in [3:0] entered seconds units (BCD)
//               tens_of_seconds_in  [3:0] entered seconds tens  (BCD)
//               units_of_minutes_in [3:0] entered minutes units (BCD)
//               loadn                     active-low load (IDLE/DONE only)
//               start, stop, clear        run / pause / abort requests
//               units_of_seconds, tens_of_seconds, units_of_minutes  live digits
//               running                   high only in RUN (registered)
//               done                      one-cycle pulse on reaching 0:00
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] units_of_seconds_in,
  input  logic [3:0] tens_of_seconds_in,
  input  logic [3:0] units_of_minutes_in,
  input  logic       loadn,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] units_of_seconds,
  output logic [3:0] tens_of_seconds,
  output logic [3:0] units_of_minutes,
  output logic       running,
  output logic       done
);

  state_t    state_q, state_d;
  bcd_time_t time_q,  time_d;
  logic      running_q;
  logic      done_q,  done_d;

  logic      tick_clr_w;
  logic      tick_en_w;
  logic      tick_w;
  bcd_time_t dec_w;
  bcd_time_t capture_w;

  second_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .CNT_W         (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr_w),
    .en   (tick_en_w),
    .tick (tick_w)
  );

  assign dec_w = bcd_dec(time_q);

  assign capture_w.min_u = clamp_digit(units_of_minutes_in, UNITS_MAX);
  assign capture_w.sec_t = clamp_digit(tens_of_seconds_in,  TENS_MAX);
  assign capture_w.sec_u = clamp_digit(units_of_seconds_in, UNITS_MAX);

  // Priority: clear > stop > start > load. A stop in any state masks the
  // lower-priority requests; it only changes state when in RUN.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    done_d     = 1'b0;
    tick_clr_w = 1'b0;
    tick_en_w  = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      time_d     = '0;
      tick_clr_w = 1'b1;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // A start on 0:00 is treated as absent, so a load can still land.
          if (start && (time_q != '0)) begin
            state_d    = RUN;
            tick_clr_w = 1'b1;
          end else if (!loadn) begin
            state_d = IDLE;
            time_d  = capture_w;
          end
        end
        RUN: begin
          tick_en_w = 1'b1;
          if (tick_w) begin
            time_d = dec_w;
            if (dec_w == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          // Resume keeps the held tick count, so the partial second survives.
          if (start) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= (state_d == RUN);
      done_q    <= done_d;
    end
  end

  assign units_of_seconds = time_q.sec_u;
  assign tens_of_seconds  = time_q.sec_t;
  assign units_of_minutes = time_q.min_u;
  assign running          = running_q;
  assign done             = done_q;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer with TICKS_PER_SEC=4.
//               A vector table covers load/clamp/run-to-done; directed
//               sequences cover borrow, pause/resume, clear and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] us_in = 4'd0, ts_in = 4'd0, um_in = 4'd0;
  logic       loadn = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] us, ts, um;
  logic       running, done;

  int errors = 0;
  int checks = 0;

  countdown_timer #(
    .TICKS_PER_SEC (TPS),
    .CNT_W         ($clog2(TPS))
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .units_of_seconds_in (us_in),
    .tens_of_seconds_in  (ts_in),
    .units_of_minutes_in (um_in),
    .loadn               (loadn),
    .start               (start),
    .stop                (stop),
    .clear               (clear),
    .units_of_seconds    (us),
    .tens_of_seconds     (ts),
    .units_of_minutes    (um),
    .running             (running),
    .done                (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ln, st, sp, cl;
    logic [3:0] i_us, i_ts, i_um;
    logic [3:0] e_um, e_ts, e_us;
    logic       e_run, e_done;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [3:0] e_um, e_ts, e_us,
                       input logic e_run, e_done);
    checks++;
    if ({um, ts, us, running, done} !== {e_um, e_ts, e_us, e_run, e_done}) begin
      errors++;
      $display("FAIL %s: got %0d:%0d%0d run=%0b done=%0b, want %0d:%0d%0d run=%0b done=%0b",
               name, um, ts, us, running, done, e_um, e_ts, e_us, e_run, e_done);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ln, st, sp, cl, input logic [3:0] i_us, i_ts, i_um);
    loadn = ln; start = st; stop = sp; clear = cl;
    us_in = i_us; ts_in = i_ts; um_in = i_um;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [3:0] i_um, i_ts, i_us);
    step(0, 0, 0, 0, i_us, i_ts, i_um);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ln st sp cl  us  ts  um   e_um e_ts e_us run done
    vecs[0]  = '{0, 0, 0, 0, 0,  3,  1,   1,   3,   0,   0,  0};  // load 1:30
    vecs[1]  = '{1, 0, 0, 0, 0,  0,  0,   1,   3,   0,   0,  0};  // hold
    vecs[2]  = '{0, 0, 0, 0, 12, 7,  15,  9,   5,   9,   0,  0};  // clamp -> 9:59
    vecs[3]  = '{0, 0, 0, 0, 0,  0,  0,   0,   0,   0,   0,  0};  // load 0:00
    vecs[4]  = '{1, 1, 0, 0, 0,  0,  0,   0,   0,   0,   0,  0};  // start on zero ignored
    vecs[5]  = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   0,   0,  0};
    vecs[6]  = '{0, 0, 0, 0, 2,  0,  0,   0,   0,   2,   0,  0};  // load 0:02
    vecs[7]  = '{1, 1, 0, 0, 0,  0,  0,   0,   0,   2,   1,  0};  // start
    vecs[8]  = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   2,   1,  0};
    vecs[9]  = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   2,   1,  0};
    vecs[10] = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   2,   1,  0};
    vecs[11] = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   1,   1,  0};  // 4 cycles -> 0:01
    vecs[12] = '{0, 0, 0, 0, 9,  5,  9,   0,   0,   1,   1,  0};  // load ignored in RUN
    vecs[13] = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   1,   1,  0};
    vecs[14] = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   1,   1,  0};
    vecs[15] = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   0,   0,  1};  // 8 cycles -> done
    vecs[16] = '{1, 0, 0, 0, 0,  0,  0,   0,   0,   0,   0,  0};  // done lasts one cycle
    vecs[17] = '{1, 1, 0, 0, 0,  0,  0,   0,   0,   0,   0,  0};  // start on 0:00 in DONE
    vecs[18] = '{1, 0, 1, 0, 0,  0,  0,   0,   0,   0,   0,  0};  // stop in DONE
    vecs[19] = '{0, 0, 0, 0, 5,  4,  0,   0,   4,   5,   0,  0};  // reload from DONE

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].ln, vecs[i].st, vecs[i].sp, vecs[i].cl,
           vecs[i].i_us, vecs[i].i_ts, vecs[i].i_um);
      check($sformatf("vec%0d", i), vecs[i].e_um, vecs[i].e_ts, vecs[i].e_us,
            vecs[i].e_run, vecs[i].e_done);
    end

    // Borrow across both seconds digits: 1:00 -> 0:59
    step(1, 0, 0, 1, 0, 0, 0);
    load(1, 0, 0);
    check("borrow_load", 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(3);
    check("borrow_before", 1, 0, 0, 1, 0);
    idle(1);
    check("borrow_after", 0, 5, 9, 1, 0);
    idle(4);
    check("borrow_next", 0, 5, 8, 1, 0);

    // Pause holds the partial second: stop 6 cycles after start
    step(1, 0, 0, 1, 0, 0, 0);
    load(0, 0, 5);
    step(1, 1, 0, 0, 0, 0, 0);
    check("pause_start", 0, 0, 5, 1, 0);
    idle(4);
    check("pause_first_dec", 0, 0, 4, 1, 0);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0);
    check("pause_enter", 0, 0, 4, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    check("pause_stop_wins", 0, 0, 4, 0, 0);
    idle(3);
    check("pause_hold", 0, 0, 4, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("resume_plus1", 0, 0, 4, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("resume_plus2", 0, 0, 3, 1, 0);

    // Clear mid-run at 0:37, then 9,9,9 clamps to 9:59
    step(1, 0, 0, 1, 0, 0, 0);
    check("clear_from_run", 0, 0, 0, 0, 0);
    load(0, 3, 8);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(4);
    check("clear_pre", 0, 3, 7, 1, 0);
    idle(1);
    step(1, 0, 0, 1, 0, 0, 0);
    check("clear_mid", 0, 0, 0, 0, 0);
    idle(5);
    check("clear_stays_idle", 0, 0, 0, 0, 0);
    load(9, 9, 9);
    check("clamp_999", 9, 5, 9, 0, 0);

    // Synchronous reset while running
    step(1, 1, 0, 0, 0, 0, 0);
    check("run_959", 9, 5, 9, 1, 0);
    idle(4);
    check("run_958", 9, 5, 8, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_mid_run", 0, 0, 0, 0, 0);
    idle(4);
    check("reset_stays_idle", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_countdown_timer
`default_nettype wire
